// File: rtl/tetris_pkg.sv
// Shared palette, default playfield geometry and line-clear state encoding
// for the Tetris playfield block.
package tetris_pkg;

    localparam int COLOR_W_DEF  = 3;
    localparam int COLS_DEF     = 10;
    localparam int ROWS_DEF     = 20;
    localparam int BLOCK_PX_DEF = 15;
    localparam int X0_DEF       = 245;
    localparam int Y0_DEF       = 90;

    typedef logic [COLOR_W_DEF-1:0] color_t;

    // {R,G,B}; BLACK doubles as the empty-cell value
    localparam color_t BLACK   = 3'b000;
    localparam color_t BLUE    = 3'b001;
    localparam color_t GREEN   = 3'b010;
    localparam color_t CYAN    = 3'b011;
    localparam color_t RED     = 3'b100;
    localparam color_t MAGENTA = 3'b101;
    localparam color_t YELLOW  = 3'b110;
    localparam color_t WHITE   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } clr_state_t;

    function automatic logic is_empty(input color_t c);
        return c == BLACK;
    endfunction

endpackage

// File: rtl/tetris_grid_render.sv
// Pure-combinational mapping from a VGA pixel coordinate to a playfield
// colour: grid lines in white, cells from the array, black outside the grid.
module tetris_grid_render
    import tetris_pkg::*;
#(
    parameter int COLS     = COLS_DEF,
    parameter int ROWS     = ROWS_DEF,
    parameter int BLOCK_PX = BLOCK_PX_DEF,
    parameter int X0       = X0_DEF,
    parameter int Y0       = Y0_DEF,
    parameter int COLOR_W  = COLOR_W_DEF
) (
    input  logic [9:0]              x,
    input  logic [9:0]              y,
    input  logic [COLOR_W-1:0]      cell_color,
    output logic [$clog2(ROWS)-1:0] cell_row,
    output logic [$clog2(COLS)-1:0] cell_col,
    output logic [COLOR_W-1:0]      shape_color
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    localparam logic [9:0] X0_V   = 10'(X0);
    localparam logic [9:0] Y0_V   = 10'(Y0);
    localparam logic [9:0] GRID_W = 10'(COLS * BLOCK_PX);
    localparam logic [9:0] GRID_H = 10'(ROWS * BLOCK_PX);
    localparam logic [9:0] PITCH  = 10'(BLOCK_PX);

    logic [9:0] dx;
    logic [9:0] dy;
    logic       in_grid;
    logic       on_line;

    // dx/dy wrap when the pixel is left of/above the grid; in_grid masks that
    assign dx = x - X0_V;
    assign dy = y - Y0_V;

    assign in_grid = (x >= X0_V) && (dx < GRID_W) && (y >= Y0_V) && (dy < GRID_H);

    assign on_line = ((dx % PITCH) == 10'd0) ||
                     ((dy % PITCH) == 10'd0) ||
                     (dx == GRID_W - 10'd1)  ||
                     (dy == GRID_H - 10'd1);

    assign cell_col = CW'(dx / PITCH);
    assign cell_row = RW'(dy / PITCH);

    always_comb begin
        shape_color = '0;
        if (in_grid) begin
            if (on_line) begin
                shape_color = {COLOR_W{1'b1}};
            end else begin
                shape_color = cell_color;
            end
        end
    end

endmodule

// File: rtl/tetris_playfield.sv
// Tetris playfield: cell storage with write and occupancy ports, a sequential
// line-clear engine, and the VGA grid renderer.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | accepting writes, waiting for clear_start
// ST_SCAN  | test row r for fullness, walking from the bottom to row 0
// ST_SHIFT | drop rows 0..r-1 down by one, row 0 emptied, r rechecked
// ST_DONE  | clear_done high for one cycle, then back to idle
module tetris_playfield
    import tetris_pkg::*;
#(
    parameter int COLS     = COLS_DEF,
    parameter int ROWS     = ROWS_DEF,
    parameter int BLOCK_PX = BLOCK_PX_DEF,
    parameter int X0       = X0_DEF,
    parameter int Y0       = Y0_DEF,
    parameter int COLOR_W  = COLOR_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [9:0]                x,
    input  logic [9:0]                y,
    input  logic                      wr_en,
    input  logic [$clog2(ROWS)-1:0]   wr_row,
    input  logic [$clog2(COLS)-1:0]   wr_col,
    input  logic [COLOR_W-1:0]        wr_color,
    input  logic [$clog2(ROWS)-1:0]   rd_row,
    input  logic [$clog2(COLS)-1:0]   rd_col,
    output logic                      rd_occupied,
    input  logic                      clear_start,
    output logic                      busy,
    output logic                      clear_done,
    output logic [$clog2(ROWS+1)-1:0] lines_cleared,
    output logic [COLOR_W-1:0]        shape_color
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int LW = $clog2(ROWS + 1);

    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
    localparam logic [LW-1:0] COUNT_MAX = LW'(ROWS);

    logic [COLOR_W-1:0] cells [ROWS][COLS];

    clr_state_t    state;
    logic [RW-1:0] r;
    logic [LW-1:0] count;

    logic          scan_full;
    logic          wr_ok;
    logic          rd_in_range;
    logic [RW-1:0] pix_row;
    logic [CW-1:0] pix_col;
    logic [COLOR_W-1:0] pix_cell;

    always_comb begin
        scan_full = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (cells[r][c] == '0) begin
                scan_full = 1'b0;
            end
        end
    end

    assign wr_ok = wr_en && !busy && (wr_row <= ROW_LAST) && (wr_col <= COL_LAST);

    // Anything outside the array reads as occupied so the controller sees walls
    assign rd_in_range = (rd_row <= ROW_LAST) && (rd_col <= COL_LAST);
    assign rd_occupied = rd_in_range ? (cells[rd_row][rd_col] != '0) : 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS; j++) begin
                    cells[i][j] <= '0;
                end
            end
            state         <= ST_IDLE;
            r             <= '0;
            count         <= '0;
            busy          <= 1'b0;
            clear_done    <= 1'b0;
            lines_cleared <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (wr_ok) begin
                        cells[wr_row][wr_col] <= wr_color;
                    end
                    if (clear_start) begin
                        r     <= ROW_LAST;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (scan_full) begin
                        state <= ST_SHIFT;
                    end else if (r == '0) begin
                        clear_done    <= 1'b1;
                        lines_cleared <= count;
                        state         <= ST_DONE;
                    end else begin
                        r <= r - 1'b1;
                    end
                end
                ST_SHIFT: begin
                    for (int i = 1; i < ROWS; i++) begin
                        if (RW'(i) <= r) begin
                            cells[i] <= cells[i-1];
                        end
                    end
                    for (int j = 0; j < COLS; j++) begin
                        cells[0][j] <= '0;
                    end
                    if (count != COUNT_MAX) begin
                        count <= count + 1'b1;
                    end
                    state <= ST_SCAN;
                end
                ST_DONE: begin
                    clear_done <= 1'b0;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pix_cell = ((pix_row <= ROW_LAST) && (pix_col <= COL_LAST)) ?
                      cells[pix_row][pix_col] : '0;

    tetris_grid_render #(
        .COLS     (COLS),
        .ROWS     (ROWS),
        .BLOCK_PX (BLOCK_PX),
        .X0       (X0),
        .Y0       (Y0),
        .COLOR_W  (COLOR_W)
    ) u_render (
        .x           (x),
        .y           (y),
        .cell_color  (pix_cell),
        .cell_row    (pix_row),
        .cell_col    (pix_col),
        .shape_color (shape_color)
    );

endmodule
